// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic mode encodings and default lane geometry
package arith_pkg;

  localparam int DEFAULT_LANE_WIDTH = 8;
  localparam int DEFAULT_LANE_COUNT = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } op_mode_t;

  typedef enum logic {
    MODE_CHAIN = 1'b0,
    MODE_SPLIT = 1'b1
  } lane_mode_t;

endpackage

// File: rtl/lane_carry_extract.sv
// rtl/lane_carry_extract.sv - combinational one-lane add/sub with MSB carry-in, carry-out and overflow
module lane_carry_extract #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             msb_carryin,
  output logic             carryout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  assign sum      = full[WIDTH-1:0];
  assign carryout = full[WIDTH];

  // The carry into any bit is recoverable as a ^ b ^ sum; only the MSB matters here.
  assign msb_carryin = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
  assign overflow    = msb_carryin ^ carryout;

endmodule

// File: rtl/adder_lanes_carry.sv
// rtl/adder_lanes_carry.sv - registered multi-lane add/sub with per-lane carry and overflow flags
// Optional sticky overflow accumulator: ADDER_LANES_STICKY_OVERFLOW_EN
module adder_lanes_carry
  import arith_pkg::*;
#(
  parameter  int LANE_WIDTH = DEFAULT_LANE_WIDTH,
  parameter  int LANE_COUNT = DEFAULT_LANE_COUNT,
  localparam int WORD_WIDTH = LANE_WIDTH * LANE_COUNT
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_A,
  input  logic [WORD_WIDTH-1:0] in_B,
  input  logic                  in_sub,
  input  logic                  in_split,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_sum,
  output logic [LANE_COUNT-1:0] out_carryin,
  output logic [LANE_COUNT-1:0] out_carryout,
  output logic [LANE_COUNT-1:0] out_overflow
`ifdef ADDER_LANES_STICKY_OVERFLOW_EN
  ,
  input  logic                  sticky_clear,
  output logic [LANE_COUNT-1:0] sticky_overflow
`endif
);

  localparam logic [LANE_COUNT-1:0] TOP_MASK = LANE_COUNT'(1) << (LANE_COUNT - 1);

  logic                  sub_op;
  logic                  split_mode;
  logic                  take_in;
  logic                  take_out;
  logic [WORD_WIDTH-1:0] nxt_sum;
  logic [LANE_COUNT-1:0] nxt_carryin;
  logic [LANE_COUNT-1:0] nxt_carryout;
  logic [LANE_COUNT-1:0] lane_ovf;
  logic [LANE_COUNT-1:0] nxt_overflow;

  assign sub_op     = (in_sub == MODE_SUB);
  assign split_mode = (in_split == MODE_SPLIT);

  assign in_ready = !out_valid || out_ready;
  assign take_in  = in_valid && in_ready;
  assign take_out = out_valid && out_ready;

  // Lane k takes its carry from lane k-1 only when the word is chained.
  for (genvar k = 0; k < LANE_COUNT; k++) begin : g_lane
    logic cin;
    logic cout;

    if (k == 0) begin : g_first
      assign cin = sub_op;
    end else begin : g_next
      assign cin = split_mode ? sub_op : g_lane[k-1].cout;
    end

    lane_carry_extract #(
      .WIDTH(LANE_WIDTH)
    ) u_lane (
      .a          (in_A[k*LANE_WIDTH +: LANE_WIDTH]),
      .b          (in_B[k*LANE_WIDTH +: LANE_WIDTH]),
      .sub        (sub_op),
      .cin        (cin),
      .sum        (nxt_sum[k*LANE_WIDTH +: LANE_WIDTH]),
      .msb_carryin(nxt_carryin[k]),
      .carryout   (cout),
      .overflow   (lane_ovf[k])
    );

    assign nxt_carryout[k] = cout;
  end

  // A chained word has one signed result, so only the top lane's overflow is meaningful.
  assign nxt_overflow = split_mode ? lane_ovf : (lane_ovf & TOP_MASK);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_carryin  <= '0;
      out_carryout <= '0;
      out_overflow <= '0;
    end else if (take_in) begin
      out_valid    <= 1'b1;
      out_sum      <= nxt_sum;
      out_carryin  <= nxt_carryin;
      out_carryout <= nxt_carryout;
      out_overflow <= nxt_overflow;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef ADDER_LANES_STICKY_OVERFLOW_EN
  // A flag transferring in the same cycle as a clear is kept.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sticky_overflow <= '0;
    end else begin
      sticky_overflow <= (sticky_clear ? '0 : sticky_overflow) |
                         (take_out ? out_overflow : '0);
    end
  end
`else
  // No sticky state in this build; take_out only feeds the accumulator.
  logic unused_take_out;
  assign unused_take_out = take_out;
`endif

endmodule
